i2c_slave: RTL and testbench

- I2C target (responder) for the team's I2C master: answers one 7-bit address, accepts write bytes and returns read bytes.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain.
- Sits on the same two-wire bus as the master.
- User side is a simple byte interface: received-byte strobe, plus a transmit-byte load strobe.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_slave.sv | 178 +++++++++++++++++
 tb/tb_i2c_slave.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels, address width.
package i2c_pkg;

   localparam int   I2C_ADDR_W = 7;
   localparam logic I2C_ACK    = 1'b0;
   localparam logic I2C_NACK   = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX_DATA   = 3'd3,
      RX_ACK    = 3'd4,
      TX_DATA   = 3'd5,
      TX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_p;
   logic                   sda_p;
   logic                   scl_s;

   // Synchroniser chains plus one extra sample for edge detection; idle bus is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_p    <= scl_sync[SYNC_STAGES-1];
         sda_p    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_p;
   assign scl_fall  = ~scl_s & scl_p;
   // SDA may only change under a steady-high SCL for START/STOP.
   assign start_det = sda_p & ~sda_s & scl_s & scl_p;
   assign stop_det  = ~sda_p & sda_s & scl_s & scl_p;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: one 7-bit address, byte receive/transmit, open-drain SDA.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W bit
// ADDR_ACK  | driving ACK for a matched address
// RX_DATA   | shifting in a write byte
// RX_ACK    | driving ACK for a received byte
// TX_DATA   | presenting a read byte, MSB first
// TX_ACK    | sampling master ACK/NACK
// WAIT_STOP | not addressed or NACKed, ignore bus until START/STOP
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_match,
   output logic       rw,
   output logic       busy
);

   i2c_state_e state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic [7:0] shift, shift_nx;
   logic [7:0] tx_sh, tx_sh_nx;
   logic       sda_low, sda_low_nx;
   logic       rw_nx, busy_nx, rx_valid_nx, tx_load_nx, addr_match_nx;
   logic [7:0] rx_data_nx;
   logic       scl_rise, scl_fall, sda_s, start_det, stop_det;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // Gating with rst_n releases the line the moment reset asserts.
   assign sda = (sda_low && rst_n) ? 1'b0 : 1'bz;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         tx_sh      <= '0;
         sda_low    <= 1'b0;
         rw         <= 1'b0;
         busy       <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         tx_load    <= 1'b0;
         addr_match <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         shift      <= shift_nx;
         tx_sh      <= tx_sh_nx;
         sda_low    <= sda_low_nx;
         rw         <= rw_nx;
         busy       <= busy_nx;
         rx_data    <= rx_data_nx;
         rx_valid   <= rx_valid_nx;
         tx_load    <= tx_load_nx;
         addr_match <= addr_match_nx;
      end
   end

   // Next-state and output decode; START/STOP override every state.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      shift_nx      = shift;
      tx_sh_nx      = tx_sh;
      sda_low_nx    = sda_low;
      rw_nx         = rw;
      busy_nx       = busy;
      rx_data_nx    = rx_data;
      rx_valid_nx   = 1'b0;
      tx_load_nx    = 1'b0;
      addr_match_nx = 1'b0;
      if (start_det) begin
         state_nx   = ADDR;
         cnt_nx     = '0;
         sda_low_nx = 1'b0;
         busy_nx    = 1'b0;
      end else if (stop_det) begin
         state_nx   = IDLE;
         cnt_nx     = '0;
         sda_low_nx = 1'b0;
         busy_nx    = 1'b0;
      end else begin
         case (state)
            ADDR: if (scl_rise) begin
               shift_nx = {shift[6:0], sda_s};
               cnt_nx   = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  // shift[6:0] already holds address bits [7:1]; sda_s is R/W.
                  if (shift[6:0] == SLAVE_ADDR) begin
                     rw_nx         = sda_s;
                     addr_match_nx = 1'b1;
                     busy_nx       = 1'b1;
                     state_nx      = ADDR_ACK;
                  end else begin
                     state_nx = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK, RX_ACK: if (scl_fall) begin
               // First fall starts the ACK bit, second fall ends it.
               if (!sda_low) begin
                  sda_low_nx = 1'b1;
               end else begin
                  sda_low_nx = 1'b0;
                  cnt_nx     = '0;
                  if (state == ADDR_ACK && rw) begin
                     tx_sh_nx   = tx_data;
                     tx_load_nx = 1'b1;
                     sda_low_nx = ~tx_data[7];
                     state_nx   = TX_DATA;
                  end else begin
                     state_nx = RX_DATA;
                  end
               end
            end
            RX_DATA: if (scl_rise) begin
               shift_nx = {shift[6:0], sda_s};
               cnt_nx   = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  rx_data_nx  = {shift[6:0], sda_s};
                  rx_valid_nx = 1'b1;
                  state_nx    = RX_ACK;
               end
            end
            TX_DATA: if (scl_fall) begin
               if (cnt == 3'd7) begin
                  sda_low_nx = 1'b0;
                  cnt_nx     = '0;
                  state_nx   = TX_ACK;
               end else begin
                  tx_sh_nx   = {tx_sh[6:0], 1'b0};
                  sda_low_nx = ~tx_sh[6];
                  cnt_nx     = cnt + 3'd1;
               end
            end
            TX_ACK: begin
               if (scl_rise && sda_s == I2C_NACK) begin
                  busy_nx  = 1'b0;
                  state_nx = WAIT_STOP;
               end else if (scl_fall) begin
                  tx_sh_nx   = tx_data;
                  tx_load_nx = 1'b1;
                  sda_low_nx = ~tx_data[7];
                  cnt_nx     = '0;
                  state_nx   = TX_DATA;
               end
            end
            default: sda_low_nx = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master plus transaction-level model checking i2c_slave.
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int Q = 5;
   localparam logic [6:0] MY_ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_sda_low = 1'b0;
   wire        sda_bus;
   logic [7:0] tx_data;
   logic       tx_load, rx_valid, addr_match, rw, busy;
   logic [7:0] rx_data;

   logic [7:0] tx_arr [8];
   int txl_cnt = 0, rxv_cnt = 0, am_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;
   logic [7:0] last_rx = 8'h00;
   int checks = 0, errors = 0;

   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);
   assign tx_data = tx_arr[txl_cnt % 8];

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(MY_ADDR), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl        (scl),
      .sda        (sda_bus),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .addr_match (addr_match),
      .rw         (rw),
      .busy       (busy)
   );

   // Event counters sampled away from the active edge.
   always @(negedge clk) begin
      if (tx_load) txl_cnt++;
      if (rx_valid) begin
         rxv_cnt++;
         last_rx = rx_data;
      end
      if (addr_match) am_cnt++;
      if (busy) busy_cnt++;
      if (!m_sda_low && sda_bus === 1'b0) dut_low_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SCL period: drive (or release) SDA mid-low, sample mid-high.
   task automatic m_bit(input logic b_out, output logic b_in);
      wait_clk(Q);
      m_sda_low = ~b_out;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      b_in = sda_bus;
      wait_clk(Q);
      scl = 1'b0;
   endtask

   task automatic m_start();
      wait_clk(Q);
      m_sda_low = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      m_sda_low = 1'b1;
      wait_clk(Q);
      scl = 1'b0;
   endtask

   task automatic m_stop();
      wait_clk(Q);
      m_sda_low = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      m_sda_low = 1'b0;
      wait_clk(2*Q);
   endtask

   task automatic m_wbyte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) m_bit(b[i], d);
      m_bit(1'b1, ack);
   endtask

   task automatic m_rbyte(output logic [7:0] b, input logic ack_out);
      logic d;
      for (int i = 7; i >= 0; i--) m_bit(1'b1, b[i]);
      m_bit(ack_out, d);
   endtask

   // Reference: the target answers only its own address, always ACKs writes.
   function automatic logic exp_ack(input logic [6:0] a);
      return (a == MY_ADDR) ? I2C_ACK : I2C_NACK;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack, d;
      logic [7:0] b;
      int rxv0, am0, txl0, low0, busy0;
      bit seen;

      for (int i = 0; i < 8; i++) tx_arr[i] = 8'($urandom);
      wait_clk(3);
      chk("rst_sda", sda_bus, 1'b1);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_strobes", {rx_valid, tx_load, addr_match}, 3'b000);
      chk("rst_rw_busy", {rw, busy}, 2'b00);
      chk("rst_state", dut.state, IDLE);
      rst_n = 1'b1;
      wait_clk(5);

      // Write 0xA5 to our address.
      rxv0 = rxv_cnt; am0 = am_cnt;
      m_start();
      m_wbyte({MY_ADDR, 1'b0}, ack);
      chk("wr_addr_ack", ack, I2C_ACK);
      chk("wr_busy", busy, 1'b1);
      m_wbyte(8'hA5, ack);
      chk("wr_data_ack", ack, I2C_ACK);
      m_stop();
      chk("wr_rxv_cnt", rxv_cnt - rxv0, 1);
      chk("wr_rx_data", last_rx, 8'hA5);
      chk("wr_am_cnt", am_cnt - am0, 1);
      chk("wr_busy_stop", busy, 1'b0);

      // Read 0x3C (ACK) then 0xC3 (NACK).
      tx_arr[txl_cnt % 8] = 8'h3C;
      tx_arr[(txl_cnt + 1) % 8] = 8'hC3;
      txl0 = txl_cnt;
      m_start();
      m_wbyte({MY_ADDR, 1'b1}, ack);
      chk("rd_addr_ack", ack, I2C_ACK);
      chk("rd_rw", rw, 1'b1);
      m_rbyte(b, I2C_ACK);
      chk("rd_byte0", b, 8'h3C);
      m_rbyte(b, I2C_NACK);
      chk("rd_byte1", b, 8'hC3);
      wait_clk(Q);
      chk("rd_release", sda_bus, 1'b1);
      chk("rd_busy_nack", busy, 1'b0);
      m_stop();
      chk("rd_txl_cnt", txl_cnt - txl0, 2);

      // Foreign address 0x51.
      rxv0 = rxv_cnt; am0 = am_cnt; txl0 = txl_cnt; low0 = dut_low_cnt; busy0 = busy_cnt;
      m_start();
      m_wbyte({7'h51, 1'b0}, ack);
      chk("na_addr_ack", ack, I2C_NACK);
      m_wbyte(8'hFF, ack);
      chk("na_data_ack", ack, I2C_NACK);
      m_stop();
      chk("na_sda_driven", dut_low_cnt - low0, 0);
      chk("na_strobes", (rxv_cnt - rxv0) + (am_cnt - am0) + (txl_cnt - txl0), 0);
      chk("na_busy", busy_cnt - busy0, 0);

      // Write 0x12, repeated START, read 0x99.
      am0 = am_cnt;
      tx_arr[txl_cnt % 8] = 8'h99;
      m_start();
      m_wbyte({MY_ADDR, 1'b0}, ack);
      chk("rs_rw0", rw, 1'b0);
      m_wbyte(8'h12, ack);
      chk("rs_rx_data", rx_data, 8'h12);
      m_start();
      m_wbyte({MY_ADDR, 1'b1}, ack);
      chk("rs_addr_ack", ack, I2C_ACK);
      chk("rs_rw1", rw, 1'b1);
      m_rbyte(b, I2C_NACK);
      chk("rs_rd_byte", b, 8'h99);
      m_stop();
      chk("rs_am_cnt", am_cnt - am0, 2);

      // STOP after four bits of a write byte.
      m_start();
      m_wbyte({MY_ADDR, 1'b0}, ack);
      rxv0 = rxv_cnt;
      for (int i = 0; i < 4; i++) m_bit(1'b1, d);
      m_stop();
      chk("ps_no_rxv", rxv_cnt - rxv0, 0);
      chk("ps_state", dut.state, IDLE);
      m_start();
      m_wbyte({MY_ADDR, 1'b0}, ack);
      m_wbyte(8'h77, ack);
      m_stop();
      chk("ps_next_rxv", rxv_cnt - rxv0, 1);
      chk("ps_next_data", last_rx, 8'h77);

      // Reset while the target holds the address ACK low.
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(((8'hA1 >> i) & 1) != 0, d);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         wait_clk(1);
         if (sda_bus === 1'b0) seen = 1;
      end
      chk("ra_ack_drive", seen, 1'b1);
      chk("ra_rw_pre", rw, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("ra_sda_rel", sda_bus, 1'b1);
      chk("ra_outputs", {rx_data, rx_valid, tx_load, addr_match, rw, busy}, 13'h0);
      wait_clk(3);
      rst_n = 1'b1;
      m_stop();
      rxv0 = rxv_cnt;
      m_start();
      m_wbyte({MY_ADDR, 1'b0}, ack);
      chk("ra_next_ack", ack, I2C_ACK);
      m_wbyte(8'h5A, ack);
      m_stop();
      chk("ra_next_data", last_rx, 8'h5A);
      chk("ra_next_rxv", rxv_cnt - rxv0, 1);

      // Randomized transactions against the reference model.
      for (int t = 0; t < 8; t++) begin
         logic [6:0] a;
         logic       rd, hit;
         int         n;
         logic [7:0] last_wr;
         a = ($urandom_range(0, 1) == 1) ? MY_ADDR : 7'($urandom);
         if (a == MY_ADDR && $urandom_range(0, 1) == 0) a = a ^ 7'h01;
         hit = (a == MY_ADDR);
         rd = 1'($urandom);
         n = $urandom_range(1, 3);
         rxv0 = rxv_cnt; am0 = am_cnt; txl0 = txl_cnt; low0 = dut_low_cnt;
         last_wr = 8'h00;
         m_start();
         m_wbyte({a, rd}, ack);
         chk("rnd_addr_ack", ack, exp_ack(a));
         for (int i = 0; i < n; i++) begin
            if (rd) begin
               m_rbyte(b, (i == n - 1) ? I2C_NACK : I2C_ACK);
               chk("rnd_rd_byte", b, hit ? tx_arr[(txl0 + i) % 8] : 8'hFF);
            end else begin
               last_wr = 8'($urandom);
               m_wbyte(last_wr, ack);
               chk("rnd_wr_ack", ack, exp_ack(a));
            end
         end
         m_stop();
         chk("rnd_rxv_cnt", rxv_cnt - rxv0, (hit && !rd) ? n : 0);
         if (hit && !rd) chk("rnd_rx_data", last_rx, last_wr);
         chk("rnd_txl_cnt", txl_cnt - txl0, (hit && rd) ? n : 0);
         chk("rnd_am_cnt", am_cnt - am0, hit ? 1 : 0);
         chk("rnd_busy", busy, 1'b0);
         if (!hit) chk("rnd_na_drive", dut_low_cnt - low0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
